// File: rtl/ext_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : ext_pkg                                                       |
// | Purpose : Shared mode encodings for the immediate / load-data extension |
// |           unit (imm_ext_pipe). Mode 7 is intentionally left unnamed:    |
// |           it is the illegal encoding and is flagged via out_err.        |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package ext_pkg;

  localparam int EXT_MODE_W = 3;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_SEXT   = 3'd0,  // sign-extend full IN_W input
    EXT_ZEXT   = 3'd1,  // zero-extend full IN_W input
    EXT_UPPER  = 3'd2,  // LUI-style: input placed in the top bits
    EXT_SEXT_B = 3'd3,  // sign-extend byte
    EXT_ZEXT_B = 3'd4,  // zero-extend byte
    EXT_SEXT_H = 3'd5,  // sign-extend halfword
    EXT_ZEXT_H = 3'd6   // zero-extend halfword
  } ext_mode_e;

endpackage : ext_pkg
`default_nettype wire

// File: rtl/ext_skid_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ext_skid_buf                                                  |
// | Purpose : Generic 2-entry valid/ready register slice. One output        |
// |           register plus one skid register give full throughput while   |
// |           keeping in_ready a pure function of registered state.         |
// | Ports   : clk, rst_n (async, active low)                                |
// |           in_valid / in_ready / in_payload   - upstream side            |
// |           out_valid / out_ready / out_payload - downstream side         |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module ext_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_payload_q, out_payload_d;
  logic             skid_full_q, skid_full_d;
  logic [WIDTH-1:0] skid_payload_q, skid_payload_d;

  logic accept;
  logic transfer;

  // in_ready only looks at the skid flag, so there is no combinational
  // path from out_ready to in_ready.
  assign in_ready    = ~skid_full_q;
  assign accept      = in_valid & in_ready;
  assign transfer    = out_valid_q & out_ready;
  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_payload_d  = out_payload_q;
    skid_full_d    = skid_full_q;
    skid_payload_d = skid_payload_q;

    if (!out_valid_q || transfer) begin
      // Output register is free this edge.
      if (skid_full_q) begin
        // Oldest waiting entry lives in the skid; accept is impossible
        // here because in_ready is low while the skid is full.
        out_valid_d   = 1'b1;
        out_payload_d = skid_payload_q;
        skid_full_d   = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_payload_d = in_payload;
        end
      end
    end else if (accept) begin
      // Output stalled: park the new entry in the skid.
      skid_full_d    = 1'b1;
      skid_payload_d = in_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_payload_q  <= '0;
      skid_full_q    <= 1'b0;
      skid_payload_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_payload_q  <= out_payload_d;
      skid_full_q    <= skid_full_d;
      skid_payload_q <= skid_payload_d;
    end
  end

endmodule : ext_skid_buf
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : imm_ext_pipe                                                  |
// | Purpose : Registered immediate / load-data extension unit. Computes the |
// |           sign/zero/upper/byte/halfword extension combinationally and   |
// |           passes {err, data} through a 2-entry skid slice.              |
// | Ports   : clk, rst_n (async, active low)                                |
// |           in_valid, in_ready, in_mode[2:0], in_data[IN_W-1:0]           |
// |           out_valid, out_ready, out_data[OUT_W-1:0], out_err            |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_err
);

  localparam int PAY_W = OUT_W + 1;

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic [PAY_W-1:0] out_payload;

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      EXT_SEXT:   ext_data = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
      EXT_ZEXT:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_data};
      EXT_UPPER:  ext_data = {in_data, {(OUT_W-IN_W){1'b0}}};
      EXT_SEXT_B: ext_data = {{(OUT_W-8){in_data[7]}}, in_data[7:0]};
      EXT_ZEXT_B: ext_data = {{(OUT_W-8){1'b0}}, in_data[7:0]};
      EXT_SEXT_H: ext_data = {{(OUT_W-16){in_data[15]}}, in_data[15:0]};
      EXT_ZEXT_H: ext_data = {{(OUT_W-16){1'b0}}, in_data[15:0]};
      default: begin
        // Illegal mode: zero data, flag the error alongside the result.
        ext_data = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  ext_skid_buf #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  ({ext_err, ext_data}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload)
  );

  assign out_err  = out_payload[OUT_W];
  assign out_data = out_payload[OUT_W-1:0];

endmodule : imm_ext_pipe
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_imm_ext_pipe                                               |
// | Purpose : Self-checking bench for imm_ext_pipe (16->32 and 16->64).     |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_mode = 3'd0;
  logic [15:0] in_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_err;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [2:0]  in_mode64 = 3'd0;
  logic [15:0] in_data64 = 16'd0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic [63:0] out_data64;
  logic        out_err64;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic        stall_seen = 1'b0;
  logic [31:0] held_data;
  logic        held_err;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  imm_ext_pipe #(.IN_W(16), .OUT_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_mode(in_mode64), .in_data(in_data64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64), .out_err(out_err64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {err, data} from the mode table, using plain arithmetic.
  function automatic logic [32:0] ref_ext(input logic [2:0] m, input logic [15:0] d);
    logic [31:0] v;
    v = 32'd0;
    case (m)
      3'd0: v = d[15] ? 32'hFFFF0000 + {16'd0, d} : {16'd0, d};
      3'd1: v = {16'd0, d};
      3'd2: v = {16'd0, d} * 32'd65536;
      3'd3: v = d[7] ? 32'hFFFFFF00 + {24'd0, d[7:0]} : {24'd0, d[7:0]};
      3'd4: v = {24'd0, d[7:0]};
      3'd5: v = d[15] ? 32'hFFFF0000 + {16'd0, d} : {16'd0, d};
      3'd6: v = {16'd0, d};
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, v};
  endfunction

  // Monitor: sample mid-cycle; the queue size is the number of held entries.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      if (stall_seen && out_valid) begin
        chk("hold_data", {32'd0, out_data}, {32'd0, held_data});
        chk("hold_err", {63'd0, out_err}, {63'd0, held_err});
      end
      stall_seen = out_valid && !out_ready;
      held_data  = out_data;
      held_err   = out_err;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", {32'd0, out_data}, {32'd0, e[31:0]});
        chk("out_err", {63'd0, out_err}, {63'd0, e[32]});
      end
      if (in_valid && in_ready) exp_q.push_back(ref_ext(in_mode, in_data));
    end
  end

  task automatic send(input logic [2:0] m, input logic [15:0] d);
    int n;
    in_mode  = m;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = 3'($urandom);
    in_data  = 16'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    rst_n = 1'b1;

    // Directed modes, out_ready high.
    out_ready = 1'b1;
    send(3'd0, 16'h8001);
    send(3'd1, 16'h8001);
    send(3'd2, 16'h1234);
    send(3'd3, 16'h0080);
    send(3'd6, 16'hF00F);
    send(3'd5, 16'h7FFF);
    send(3'd7, 16'hFFFF);
    send(3'd0, 16'h0001);
    send(3'd4, 16'hFF80);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: A in output reg, B in skid, C stalled.
    out_ready = 1'b0;
    send(3'd0, 16'hA00A);
    send(3'd1, 16'hB00B);
    in_mode  = 3'd5;
    in_data  = 16'hC00C;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("c_stalled", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    send(3'd5, 16'hC00C);
    repeat (4) @(posedge clk);
    #1;

    // Random back-to-back stream.
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_mode  = 3'($urandom);
      in_data  = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // Random stream with random back-pressure.
    for (int i = 0; i < 200; i++) begin
      out_ready = 1'($urandom);
      if (!in_valid || in_ready) begin
        in_valid = 1'($urandom);
        in_mode  = 3'($urandom);
        in_data  = 16'($urandom);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset with both entries full.
    out_ready = 1'b0;
    send(3'd0, 16'h1111);
    send(3'd1, 16'h2222);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_data", {32'd0, out_data}, 64'd0);
    exp_q.delete();
    stall_seen = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 16->64 instance.
    in_mode64  = 3'd0;
    in_data64  = 16'h8000;
    in_valid64 = 1'b1;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    chk("w64_valid", {63'd0, out_valid64}, 64'd1);
    chk("w64_sext", out_data64, 64'hFFFFFFFFFFFF8000);
    chk("w64_err", {63'd0, out_err64}, 64'd0);
    in_mode64  = 3'd2;
    in_data64  = 16'h1234;
    in_valid64 = 1'b1;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    chk("w64_upper", out_data64, 64'h1234000000000000);
    @(posedge clk);
    #1;
    chk("w64_drain", {63'd0, out_valid64}, 64'd0);

    chk("queue_empty", {32'd0, exp_q.size()}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_imm_ext_pipe
`default_nettype wire
